// File: rtl/line_adaptor_pkg.sv
// Shared types and default geometry for the cache-line <-> memory-burst adaptor.
package line_adaptor_pkg;

  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Splits a line writeback into BEATS memory beats and assembles a line fill from BEATS beats.
// Latency: resp_o the cycle after the last beat; memory stalls via resp_i=0, requestors hold read_i/write_i until resp_o.
module line_burst_adaptor #(
  parameter int LINE_WIDTH = line_adaptor_pkg::LINE_WIDTH,
  parameter int BEAT_WIDTH = line_adaptor_pkg::BEAT_WIDTH,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  output logic [BEAT_WIDTH-1:0] burst_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);
  import line_adaptor_pkg::*;

  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] LAST = KW'(BEATS - 1);

  state_t                state;
  logic [KW-1:0]         k;
  logic [LINE_WIDTH-1:0] line_q;

  // Low address bits are dropped by line alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[4:0];

  assign burst_o = line_q[k*BEAT_WIDTH +: BEAT_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
      line_o    <= '0;
      line_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          if (write_i) begin
            state     <= WRITE;
            write_o   <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
            k         <= '0;
            line_q    <= line_i;
          end else if (read_i) begin
            state     <= READ;
            read_o    <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
            k         <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[k*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
            k <= (k == LAST) ? '0 : k + 1'b1;
            if (k == LAST) begin
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            k <= (k == LAST) ? '0 : k + 1'b1;
            if (k == LAST) begin
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          // Requests still held by the requestor this cycle are deliberately not accepted.
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Table-driven fill/writeback vectors with a scoreboard, plus reset and spurious-response sequences.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  line_burst_adaptor dut (
    .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [31:0]      addr;
    logic [255:0]     line;
    logic [3:0][63:0] beats;
    logic [3:0][3:0]  gap;
    logic [31:0]      exp_addr;
    logic [255:0]     exp_line;
  } vec_t;

  vec_t         vecs[4];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [255:0] line_exp_q[$];
  logic [63:0]  beat_exp_q[$];
  logic [255:0] last_fill = '0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] BD = 64'hDDDD_DDDD_DDDD_DDDD;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    logic [1:0]   busy;
    logic [63:0]  eb;
    logic [255:0] el;
    busy = v.wr ? 2'b01 : 2'b10;
    chk("idle_req_outs", {read_o, write_o}, 2'b00);
    read_i    = v.rd;
    write_i   = v.wr;
    address_i = v.addr;
    line_i    = v.line;
    if (v.wr) for (int b = 0; b < 4; b++) beat_exp_q.push_back(v.line[b*64 +: 64]);
    else line_exp_q.push_back(v.exp_line);
    @(negedge clk);
    chk("req_outs_after_accept", {read_o, write_o}, busy);
    chk("address_o", address_o, v.exp_addr);
    for (int b = 0; b < 4; b++) begin
      resp_i = 1'b0;
      for (int g = 0; g < int'(v.gap[b]); g++) begin
        @(negedge clk);
        chk("req_outs_stall", {read_o, write_o}, busy);
        chk("resp_o_stall", resp_o, 1'b0);
      end
      if (v.wr) begin
        if (beat_exp_q.size() == 0) chk("beat_queue_empty", 1'b1, 1'b0);
        else begin
          eb = beat_exp_q.pop_front();
          chk("burst_o", burst_o, eb);
        end
        chk("line_o_hold_during_write", line_o, last_fill);
      end
      resp_i  = 1'b1;
      burst_i = v.beats[b];
      @(negedge clk);
    end
    resp_i  = 1'b0;
    burst_i = '0;
    chk("resp_o_after_last_beat", resp_o, 1'b1);
    chk("req_outs_in_done", {read_o, write_o}, 2'b00);
    chk("address_o_stable", address_o, v.exp_addr);
    if (!v.wr) begin
      if (line_exp_q.size() == 0) chk("line_queue_empty", 1'b1, 1'b0);
      else begin
        el = line_exp_q.pop_front();
        chk("line_o_fill", line_o, el);
        last_fill = el;
      end
    end
    // Requestor still holds the request during DONE; it must not be re-accepted.
    @(negedge clk);
    read_i  = 1'b0;
    write_i = 1'b0;
    chk("resp_o_one_cycle", resp_o, 1'b0);
    chk("no_reaccept", {read_o, write_o}, 2'b00);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h1234_567C, line: '0,
                beats: {B4, B3, B2, B1}, gap: {4'd0, 4'd0, 4'd0, 4'd0},
                exp_addr: 32'h1234_5660, exp_line: {B4, B3, B2, B1}};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0047, line: {BD, BC, BB, BA},
                beats: '0, gap: {4'd0, 4'd0, 4'd0, 4'd0},
                exp_addr: 32'h0000_0040, exp_line: '0};
    vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'h8000_001F, line: '0,
                beats: {B1, B2, B3, B4}, gap: {4'd5, 4'd1, 4'd3, 4'd0},
                exp_addr: 32'h8000_0000, exp_line: {B1, B2, B3, B4}};
    vecs[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'hFFFF_FFFF, line: {BA, BD, B3, BC},
                beats: '0, gap: {4'd0, 4'd1, 4'd0, 4'd2},
                exp_addr: 32'hFFFF_FFE0, exp_line: '0};

    rst_n = 1'b0; read_i = 0; write_i = 0; resp_i = 0;
    address_i = '0; line_i = '0; burst_i = '0;
    #2;
    chk("reset_line_o", line_o, '0);
    chk("reset_address_o", address_o, '0);
    chk("reset_ctrl", {read_o, write_o, resp_o}, 3'b000);
    chk("reset_burst_o", burst_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run(vecs[i]);

    // Stalled fill with gaps 0,3,1,5 and the original beat values.
    begin
      vec_t s;
      s = vecs[0];
      s.gap = {4'd5, 4'd1, 4'd3, 4'd0};
      run(s);
    end

    // Spurious acknowledges in IDLE must not disturb anything.
    resp_i = 1'b1; burst_i = '1;
    repeat (2) @(negedge clk);
    resp_i = 1'b0; burst_i = '0;
    chk("spurious_line_o", line_o, last_fill);
    chk("spurious_ctrl", {read_o, write_o, resp_o}, 3'b000);
    run(vecs[2]);

    // Reset in the middle of a fill, after two beats.
    read_i = 1'b1; address_i = 32'h1234_567C;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = vecs[0].beats[b];
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = '0;
    chk("midburst_read_o", read_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_line_o", line_o, '0);
    chk("midrst_address_o", address_o, '0);
    chk("midrst_ctrl", {read_o, write_o, resp_o}, 3'b000);
    chk("midrst_burst_o", burst_o, '0);
    read_i = 1'b0;
    last_fill = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {read_o, write_o, resp_o}, 3'b000);
    run(vecs[0]);
    run(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
